double_divider: RTL and testbench
=================================

Name: double_divider

Overview:
- Multi-cycle IEEE-754 binary64 divider, z = a / b; the division counterpart of the team's double multiplier.
- Uses the same compute/complete handshake, so datapath sequencers can drive either unit interchangeably.
- Computes the mantissa quotient with an iterative restoring divider, one quotient bit per enabled cycle.
- Rounds to nearest, ties to even.

Parameters:
- QBITS, 56, quotient bits produced per operation (53 mantissa + guard + round + 1 normalisation spare).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- clk_en  in  1  clock enable; when low, all registers hold.
- compute  in  1  start request; sampled only in IDLE.
- a  in  64  dividend, binary64.
- b  in  64  divisor, binary64.
- z  out  64  quotient, binary64; held until the next accepted compute.
- complete  out  1  one-cycle pulse when z is valid.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, any state, mid-operation included): state=IDLE, z=0, complete=0, busy=0; the in-flight result is discarded.
- clk_en=0 freezes state and all registers. complete stays asserted if the unit froze in DONE.
- compute is ignored while busy. a and b are captured in UNPACK, so the caller must hold them for one cycle after compute is accepted.
- State flow:
  - IDLE -> UNPACK (on compute).
  - UNPACK -> SPECIAL.
  - SPECIAL -> DONE (special case) or NORM_A.
  - NORM_A loops until a_m[52]=1, then NORM_B.
  - NORM_B loops until b_m[52]=1, then DIV_INIT.
  - DIV_INIT -> DIV_ITER (QBITS cycles) -> DIV_POST -> NORM_2.
  - NORM_2 loops while z_e < -1022, then ROUND -> PACK -> DONE -> IDLE.
- Unpack: 53-bit mantissa, 13-bit signed unbiased exponent (field - 1023).
  - Exponent field 0: e = -1022, hidden bit 0.
  - Otherwise: hidden bit 1.
- Special cases (z sign = a_sign ^ b_sign unless NaN; NaN = 64'h7FF8_0000_0000_0000), in priority order:
  - a or b NaN -> NaN.
  - inf/inf -> NaN.
  - 0/0 -> NaN.
  - a inf -> inf.
  - b inf -> signed zero.
  - b zero -> signed inf.
  - a zero -> signed zero.
- DIV_INIT: r = {1'b0, a_m}, q = 0, count = 0, z_e = a_e - b_e.
- DIV_ITER (per cycle):
  - q = q<<1.
  - If r >= b_m: r -= b_m and q[0] = 1.
  - r = r<<1; count++.
  - Exit after count = QBITS-1.
- DIV_POST:
  - If q[55]=1: m = q[55:3], guard = q[2], round = q[1], sticky = q[0] | (r != 0).
  - Else: m = q[54:2], guard = q[1], round = q[0], sticky = (r != 0), z_e -= 1.
- NORM_2 (per cycle while z_e < -1022):
  - m >>= 1, z_e++.
  - guard <= m[0]; round <= guard; sticky |= round.
- ROUND: if guard & (round | sticky | m[0]), m += 1. On carry out of bit 52, m = 1<<52 and z_e++.
- PACK:
  - Default: fraction = m[51:0], exponent field = z_e + 1023.
  - If z_e = -1022 and m[52]=0, exponent field = 0 (subnormal).
  - If z_e > 1023, z = signed inf.
- DONE: complete=1 for one cycle, then IDLE.
- Latency, counted from the cycle compute is sampled high in IDLE to the cycle complete is high:
  - 3 for special cases.
  - 66 for normal operands without underflow.
  - +1 per NORM_A/NORM_B shift for subnormal inputs.
  - +1 per NORM_2 shift.

Decomposition:
- Package fp64_pkg:
  - constants FP64_BIAS=1023, FP64_EMIN=-1022, FP64_EMAX=1023, FP64_QNAN, FP64_INF_EXP=11'h7FF.
  - state enum typedef.
  - struct fp64_unpacked_t {sign, exp[12:0], mant[52:0]}.
- Sub-module double_mantissa_divider:
  - contains the restoring r/q/count loop, started by DIV_INIT.
  - returns q, remainder-nonzero flag, and done.

Test Plan:
- 6.0/2.0 (a=64'h4018000000000000, b=64'h4000000000000000) -> z=64'h4008000000000000; complete pulses exactly 66 cycles after compute; busy high throughout.
- 1.0/3.0 (64'h3FF0000000000000 / 64'h4008000000000000) -> z=64'h3FD5555555555555 (round-to-even path exercised).
- Special cases, each -> complete after 3 cycles:
  - 1.0/+0.0 -> 64'h7FF0000000000000.
  - -1.0/+0.0 -> 64'hFFF0000000000000.
  - 0.0/0.0 -> 64'h7FF8000000000000.
  - inf/inf -> 64'h7FF8000000000000.
  - 1.0/inf -> 64'h0000000000000000.
- Boundaries:
  - Underflow: 64'h0010000000000000 / 2.0 -> 64'h0008000000000000 (one NORM_2 shift, latency 67).
  - Overflow: 64'h7FEFFFFFFFFFFFFF / 0.5 -> 64'h7FF0000000000000.
- Robustness:
  - Stall: clk_en low for 10 cycles during DIV_ITER -> same z, latency extended by 10.
  - Reset: rst pulsed at cycle 30 -> complete=0, z=0, busy=0 immediately.
  - Busy: a compute pulse while busy is ignored, with no second complete.

Source files
------------

// File: rtl/fp64_pkg.sv
// fp64_pkg: binary64 constants, divider state encoding and unpacked-operand helpers
package fp64_pkg;
  localparam logic signed [12:0] FP64_BIAS = 13'sd1023;
  localparam logic signed [12:0] FP64_EMIN = -13'sd1022;
  localparam logic signed [12:0] FP64_EMAX = 13'sd1023;
  localparam logic [63:0] FP64_QNAN = 64'h7FF8_0000_0000_0000;
  localparam logic [10:0] FP64_INF_EXP = 11'h7FF;
  typedef enum logic [3:0] {
    IDLE, UNPACK, SPECIAL, NORM_A, NORM_B, DIV_INIT,
    DIV_ITER, DIV_POST, NORM_2, ROUND, PACK, DONE
  } state_t;
  typedef struct packed {
    logic sign;
    logic signed [12:0] exp;
    logic [52:0] mant;
  } fp64_unpacked_t;
  function automatic fp64_unpacked_t unpack(input logic [63:0] x);
    return '{
      sign: x[63],
      exp: (x[62:52] == 11'd0) ? FP64_EMIN : $signed({2'b00, x[62:52]}) - FP64_BIAS,
      mant: {|x[62:52], x[51:0]}
    };
  endfunction
  function automatic logic is_max_exp(input fp64_unpacked_t x);
    return x.exp == $signed({2'b00, FP64_INF_EXP}) - FP64_BIAS;
  endfunction
endpackage

// File: rtl/double_mantissa_divider.sv
// double_mantissa_divider: restoring divider producing one quotient bit per enabled cycle
module double_mantissa_divider #(
  parameter int QBITS = 56
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             start,
  input  logic [52:0]      a_m,
  input  logic [52:0]      b_m,
  output logic [QBITS-1:0] q,
  output logic             rem_nz,
  output logic             done
);
  localparam int CW = $clog2(QBITS);
  logic [53:0] r, rn;
  logic [CW-1:0] count;
  logic run, ge;
  assign ge = r >= {1'b0, b_m};
  assign rn = ge ? r - {1'b0, b_m} : r;
  assign rem_nz = |r;
  assign done = run && count == CW'(QBITS - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r <= '0;
      q <= '0;
      count <= '0;
      run <= 1'b0;
    end else if (clk_en) begin
      if (start) begin
        r <= {1'b0, a_m};
        q <= '0;
        count <= '0;
        run <= 1'b1;
      end else if (run) begin
        q <= {q[QBITS-2:0], ge};
        r <= rn << 1;
        count <= count + 1'b1;
        run <= !done;
      end
    end
  end
endmodule

// File: rtl/double_divider.sv
// double_divider: multi-cycle binary64 divider z = a / b, round to nearest even
module double_divider
  import fp64_pkg::*;
#(
  parameter int QBITS = 56
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic        compute,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] z,
  output logic        complete,
  output logic        busy
);
  state_t state, state_nxt;
  fp64_unpacked_t ua, ub;
  logic signed [12:0] z_e;
  logic [52:0] m;
  logic [53:0] m_inc;
  logic g, rr, st, z_s;
  logic [QBITS-1:0] q;
  logic rem_nz, div_done;
  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, special;
  logic [63:0] special_z;
  double_mantissa_divider #(.QBITS(QBITS)) u_div (
    .clk(clk), .rst(rst), .clk_en(clk_en), .start(state == DIV_INIT),
    .a_m(ua.mant), .b_m(ub.mant), .q(q), .rem_nz(rem_nz), .done(div_done)
  );
  assign z_s = ua.sign ^ ub.sign;
  assign m_inc = {1'b0, m} + 54'd1;
  assign complete = state == DONE;
  assign busy = state != IDLE;
  always_comb begin
    a_nan = is_max_exp(ua) && ua.mant[51:0] != '0;
    b_nan = is_max_exp(ub) && ub.mant[51:0] != '0;
    a_inf = is_max_exp(ua) && ua.mant[51:0] == '0;
    b_inf = is_max_exp(ub) && ub.mant[51:0] == '0;
    a_zero = ua.mant == '0;
    b_zero = ub.mant == '0;
    special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
    special_z = (a_nan | b_nan | (a_inf & b_inf) | (a_zero & b_zero)) ? FP64_QNAN :
                (a_inf | b_zero) ? {z_s, FP64_INF_EXP, 52'b0} : {z_s, 63'b0};
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     state_nxt = compute ? UNPACK : IDLE;
      UNPACK:   state_nxt = SPECIAL;
      SPECIAL:  state_nxt = special ? DONE : NORM_A;
      NORM_A:   state_nxt = ua.mant[52] ? NORM_B : NORM_A;
      NORM_B:   state_nxt = ub.mant[52] ? DIV_INIT : NORM_B;
      DIV_INIT: state_nxt = DIV_ITER;
      DIV_ITER: state_nxt = div_done ? DIV_POST : DIV_ITER;
      DIV_POST: state_nxt = NORM_2;
      NORM_2:   state_nxt = (z_e < FP64_EMIN) ? NORM_2 : ROUND;
      ROUND:    state_nxt = PACK;
      PACK:     state_nxt = DONE;
      default:  state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else if (clk_en) state <= state_nxt;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ua <= '0;
      ub <= '0;
      z_e <= '0;
      m <= '0;
      g <= 1'b0;
      rr <= 1'b0;
      st <= 1'b0;
      z <= '0;
    end else if (clk_en) begin
      case (state)
        UNPACK: begin
          ua <= unpack(a);
          ub <= unpack(b);
        end
        SPECIAL: if (special) z <= special_z;
        NORM_A: if (!ua.mant[52]) begin
          ua.mant <= ua.mant << 1;
          ua.exp <= ua.exp - 13'sd1;
        end
        NORM_B: if (!ub.mant[52]) begin
          ub.mant <= ub.mant << 1;
          ub.exp <= ub.exp - 13'sd1;
        end
        DIV_INIT: z_e <= ua.exp - ub.exp;
        DIV_POST: if (q[55]) begin
          m <= q[55:3];
          g <= q[2];
          rr <= q[1];
          st <= q[0] | rem_nz;
        end else begin
          m <= q[54:2];
          g <= q[1];
          rr <= q[0];
          st <= rem_nz;
          z_e <= z_e - 13'sd1;
        end
        NORM_2: if (z_e < FP64_EMIN) begin
          m <= m >> 1;
          z_e <= z_e + 13'sd1;
          g <= m[0];
          rr <= g;
          st <= st | rr;
        end
        ROUND: if (g & (rr | st | m[0])) begin
          m <= m_inc[53] ? {1'b1, 52'b0} : m_inc[52:0];
          if (m_inc[53]) z_e <= z_e + 13'sd1;
        end
        PACK: z <= (z_e > FP64_EMAX) ? {z_s, FP64_INF_EXP, 52'b0} :
                   {z_s, (z_e == FP64_EMIN && !m[52]) ? 11'd0 : 11'(z_e + FP64_BIAS), m[51:0]};
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_double_divider.sv
// tb_double_divider: directed self-checking bench for double_divider
module tb_double_divider;
  logic clk = 1'b0, rst = 1'b1, clk_en = 1'b1, compute = 1'b0;
  logic [63:0] a = '0, b = '0, z;
  logic complete, busy;
  int passed = 0, total = 0;
  double_divider dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .compute(compute),
    .a(a), .b(b), .z(z), .complete(complete), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic run_op(input logic [63:0] ia, input logic [63:0] ib, input int stall_at,
                        input int pulse_at, output logic [63:0] zr, output int lat,
                        output logic busy_ok, output logic tail_ok);
    a = ia;
    b = ib;
    compute = 1'b1;
    busy_ok = 1'b1;
    @(posedge clk);
    #1;
    compute = 1'b0;
    lat = 1;
    while (!complete && lat < 3000) begin
      busy_ok = busy_ok & busy;
      clk_en = !(stall_at > 0 && lat >= stall_at && lat < stall_at + 10);
      compute = (lat == pulse_at);
      @(posedge clk);
      #1;
      lat++;
    end
    compute = 1'b0;
    clk_en = 1'b1;
    busy_ok = busy_ok & busy;
    zr = z;
    @(posedge clk);
    #1;
    tail_ok = !complete && !busy;
  endtask
  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (z !== 64'h0) $display("FAIL reset_z got=%h exp=0", z); else passed++;
    total++; if (complete !== 1'b0) $display("FAIL reset_complete got=%b exp=0", complete); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask
  task automatic test_basic();
    logic [63:0] zr;
    int lat;
    logic bok, tok;
    run_op(64'h4018000000000000, 64'h4000000000000000, 0, 0, zr, lat, bok, tok);
    total++; if (zr !== 64'h4008000000000000) $display("FAIL div_6_2 got=%h exp=4008000000000000", zr); else passed++;
    total++; if (lat !== 66) $display("FAIL div_6_2_latency got=%0d exp=66", lat); else passed++;
    total++; if (bok !== 1'b1) $display("FAIL div_6_2_busy got=%b exp=1", bok); else passed++;
    total++; if (tok !== 1'b1) $display("FAIL div_6_2_pulse got=%b exp=1", tok); else passed++;
  endtask
  task automatic test_round();
    logic [63:0] zr;
    int lat;
    logic bok, tok;
    run_op(64'h3FF0000000000000, 64'h4008000000000000, 0, 0, zr, lat, bok, tok);
    total++; if (zr !== 64'h3FD5555555555555) $display("FAIL div_1_3 got=%h exp=3fd5555555555555", zr); else passed++;
    total++; if (lat !== 66) $display("FAIL div_1_3_latency got=%0d exp=66", lat); else passed++;
  endtask
  task automatic test_special();
    logic [63:0] va[5], vb[5], vz[5];
    logic [63:0] zr;
    int lat;
    logic bok, tok;
    va = '{64'h3FF0000000000000, 64'hBFF0000000000000, 64'h0, 64'h7FF0000000000000, 64'h3FF0000000000000};
    vb = '{64'h0, 64'h0, 64'h0, 64'h7FF0000000000000, 64'h7FF0000000000000};
    vz = '{64'h7FF0000000000000, 64'hFFF0000000000000, 64'h7FF8000000000000, 64'h7FF8000000000000, 64'h0};
    for (int i = 0; i < 5; i++) begin
      run_op(va[i], vb[i], 0, 0, zr, lat, bok, tok);
      total++; if (zr !== vz[i]) $display("FAIL special_%0d got=%h exp=%h", i, zr, vz[i]); else passed++;
      total++; if (lat !== 3) $display("FAIL special_%0d_latency got=%0d exp=3", i, lat); else passed++;
    end
  endtask
  task automatic test_underflow();
    logic [63:0] zr;
    int lat;
    logic bok, tok;
    run_op(64'h0010000000000000, 64'h4000000000000000, 0, 0, zr, lat, bok, tok);
    total++; if (zr !== 64'h0008000000000000) $display("FAIL underflow got=%h exp=0008000000000000", zr); else passed++;
    total++; if (lat !== 67) $display("FAIL underflow_latency got=%0d exp=67", lat); else passed++;
  endtask
  task automatic test_overflow();
    logic [63:0] zr;
    int lat;
    logic bok, tok;
    run_op(64'h7FEFFFFFFFFFFFFF, 64'h3FE0000000000000, 0, 0, zr, lat, bok, tok);
    total++; if (zr !== 64'h7FF0000000000000) $display("FAIL overflow got=%h exp=7ff0000000000000", zr); else passed++;
  endtask
  task automatic test_stall();
    logic [63:0] zr;
    int lat;
    logic bok, tok;
    run_op(64'h4018000000000000, 64'h4000000000000000, 20, 0, zr, lat, bok, tok);
    total++; if (zr !== 64'h4008000000000000) $display("FAIL stall_z got=%h exp=4008000000000000", zr); else passed++;
    total++; if (lat !== 76) $display("FAIL stall_latency got=%0d exp=76", lat); else passed++;
  endtask
  task automatic test_busy();
    logic [63:0] zr;
    int lat, seen;
    logic bok, tok;
    run_op(64'h4018000000000000, 64'h4000000000000000, 0, 10, zr, lat, bok, tok);
    total++; if (zr !== 64'h4008000000000000) $display("FAIL busy_z got=%h exp=4008000000000000", zr); else passed++;
    total++; if (lat !== 66) $display("FAIL busy_latency got=%0d exp=66", lat); else passed++;
    seen = 0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (complete || busy) seen++;
    end
    total++; if (seen !== 0) $display("FAIL busy_second_op got=%0d exp=0", seen); else passed++;
  endtask
  task automatic test_reset_mid();
    int seen;
    a = 64'h4018000000000000;
    b = 64'h4000000000000000;
    compute = 1'b1;
    @(posedge clk);
    #1;
    compute = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    total++; if (complete !== 1'b0) $display("FAIL mid_reset_complete got=%b exp=0", complete); else passed++;
    total++; if (z !== 64'h0) $display("FAIL mid_reset_z got=%h exp=0", z); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL mid_reset_busy got=%b exp=0", busy); else passed++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (complete || busy) seen++;
    end
    total++; if (seen !== 0) $display("FAIL mid_reset_discard got=%0d exp=0", seen); else passed++;
  endtask
  initial begin
    test_reset();
    test_basic();
    test_round();
    test_special();
    test_underflow();
    test_overflow();
    test_stall();
    test_busy();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
